// File: rtl/orientation_pkg.sv
// Shared orientation definitions: code constants, stabilizer FSM encoding,
// and the idle (neutral) LED pattern for the 3x3 attitude display.
package orientation_pkg;

    // Orientation codes as produced by the orientation encoder
    localparam logic [3:0] ORI_NEUTRAL    = 4'd0;
    localparam logic [3:0] ORI_UP         = 4'd1;
    localparam logic [3:0] ORI_UP_RIGHT   = 4'd2;
    localparam logic [3:0] ORI_RIGHT      = 4'd3;
    localparam logic [3:0] ORI_DOWN_RIGHT = 4'd4;
    localparam logic [3:0] ORI_DOWN       = 4'd5;
    localparam logic [3:0] ORI_DOWN_LEFT  = 4'd6;
    localparam logic [3:0] ORI_LEFT       = 4'd7;
    localparam logic [3:0] ORI_UP_LEFT    = 4'd8;
    localparam logic [3:0] ORI_MAX        = 4'd8;

    // Stabilizer FSM: STABLE holds the committed code, PENDING counts a candidate
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Centre LED lit, i.e. the neutral orientation
    localparam logic [8:0] LED_CENTER = 9'b000010000;

endpackage

// File: rtl/orientation_stabilizer_if.sv
// Sample stream in, debounced orientation and status out.
// sample_valid is a one-cycle strobe with no back-pressure: the stabilizer
// accepts orientation_in on every rising edge where sample_valid is high,
// so the producer may strobe every cycle. All slave outputs are registered.
interface orientation_stabilizer_if;
    logic       sample_valid;
    logic [3:0] orientation_in;
    logic [3:0] orientation_out;
    logic       changed;
    logic [8:0] led_grid;
    logic       pending;
    logic       code_err;

    // Encoder side: drives samples, observes the debounced result
    modport master (
        output sample_valid, orientation_in,
        input  orientation_out, changed, led_grid, pending, code_err
    );

    // Stabilizer side
    modport slave (
        input  sample_valid, orientation_in,
        output orientation_out, changed, led_grid, pending, code_err
    );
endinterface

// File: rtl/orientation_led_map.sv
// Pure combinational lookup from orientation code to one-hot 3x3 LED grid.
// Grid is row-major with bit0 at top-left; illegal codes show the centre.
module orientation_led_map
    import orientation_pkg::*;
(
    input  logic [3:0] code,
    output logic [8:0] led
);

    // Map each direction onto its compass position around the centre LED
    always_comb begin
        led = LED_CENTER;
        case (code)
            ORI_UP_LEFT:    led = 9'b000000001;
            ORI_UP:         led = 9'b000000010;
            ORI_UP_RIGHT:   led = 9'b000000100;
            ORI_LEFT:       led = 9'b000001000;
            ORI_NEUTRAL:    led = 9'b000010000;
            ORI_RIGHT:      led = 9'b000100000;
            ORI_DOWN_LEFT:  led = 9'b001000000;
            ORI_DOWN:       led = 9'b010000000;
            ORI_DOWN_RIGHT: led = 9'b100000000;
            default:        led = LED_CENTER;
        endcase
    end

endmodule

// File: rtl/orientation_stabilizer.sv
// Debounces the orientation code: a new code is committed only after it has
// been seen on STABLE_COUNT consecutive accepted samples. Illegal codes are
// flagged in a sticky error bit and otherwise ignored. The FSM state is
// visible on the pending output.
module orientation_stabilizer
    import orientation_pkg::*;
#(
    parameter int STABLE_COUNT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    orientation_stabilizer_if.slave   bus
);

    localparam int                CNT_W      = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(STABLE_COUNT);

    generate
        if (STABLE_COUNT < 1 || STABLE_COUNT > 255) begin : g_bad_count
            $error("orientation_stabilizer: STABLE_COUNT must be 1..255");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        out_q, out_d;
    logic [8:0]        led_q, led_d;
    logic              chg_q, chg_d;
    logic              err_q, err_d;

    logic              code_legal;
    logic              accept;
    logic              commit;
    logic [3:0]        commit_code;
    logic [8:0]        commit_led;

    assign code_legal = (bus.orientation_in <= ORI_MAX);
    assign accept     = bus.sample_valid && code_legal;

    orientation_led_map u_led_map (
        .code (commit_code),
        .led  (commit_led)
    );

    // State and output registers; reset discards any partial run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cand_q  <= ORI_NEUTRAL;
            cnt_q   <= '0;
            out_q   <= ORI_NEUTRAL;
            led_q   <= LED_CENTER;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            led_q   <= led_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    // Next-state: track the candidate run and decide when to commit
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_code = cand_q;
        if (accept) begin
            case (state_q)
                STABLE: begin
                    if (bus.orientation_in != out_q) begin
                        cand_d = bus.orientation_in;
                        if (STABLE_COUNT == 1) begin
                            // A single sample is already a full run
                            commit      = 1'b1;
                            commit_code = bus.orientation_in;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (bus.orientation_in == cand_q) begin
                        if (cnt_q + CNT_ONE == CNT_TARGET) begin
                            commit  = 1'b1;
                            cnt_d   = '0;
                            state_d = STABLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (bus.orientation_in == out_q) begin
                        // Jitter returned to the committed code: drop the run
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else begin
                        cand_d = bus.orientation_in;
                        cnt_d  = CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values: commit updates code and LEDs, pulses changed
    always_comb begin
        out_d = out_q;
        led_d = led_q;
        chg_d = 1'b0;
        err_d = err_q | (bus.sample_valid && !code_legal);
        if (commit) begin
            out_d = commit_code;
            led_d = commit_led;
            chg_d = 1'b1;
        end
    end

    assign bus.orientation_out = out_q;
    assign bus.led_grid        = led_q;
    assign bus.changed         = chg_q;
    assign bus.pending         = (state_q == PENDING);
    assign bus.code_err        = err_q;

endmodule

// File: tb/tb_orientation_stabilizer.sv
// Directed bench for orientation_stabilizer: a STABLE_COUNT=4 instance for
// the main sequences and a STABLE_COUNT=1 instance for immediate commits.
module tb_orientation_stabilizer;
    import orientation_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    orientation_stabilizer_if bus4();
    orientation_stabilizer_if bus1();

    orientation_stabilizer #(.STABLE_COUNT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    orientation_stabilizer #(.STABLE_COUNT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Expected committed codes of dut4, in order
    logic [3:0] exp_q[$];

    // LED pattern per code, taken from the display layout
    logic [8:0] led_tab [9] = '{9'h010, 9'h002, 9'h004, 9'h020, 9'h100,
                                9'h080, 9'h040, 9'h008, 9'h001};

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect4(input string tag, input logic [3:0] o, input logic [8:0] l,
                           input logic ch, input logic pe, input logic er);
        check($sformatf("%s.out", tag),     bus4.orientation_out, o);
        check($sformatf("%s.led", tag),     bus4.led_grid, l);
        check($sformatf("%s.changed", tag), bus4.changed, ch);
        check($sformatf("%s.pending", tag), bus4.pending, pe);
        check($sformatf("%s.err", tag),     bus4.code_err, er);
    endtask

    task automatic expect1(input string tag, input logic [3:0] o, input logic [8:0] l,
                           input logic ch, input logic pe, input logic er);
        check($sformatf("%s.out", tag),     bus1.orientation_out, o);
        check($sformatf("%s.led", tag),     bus1.led_grid, l);
        check($sformatf("%s.changed", tag), bus1.changed, ch);
        check($sformatf("%s.pending", tag), bus1.pending, pe);
        check($sformatf("%s.err", tag),     bus1.code_err, er);
    endtask

    // ---------------- drivers (called at a negedge, return at the next) ----------------
    task automatic cycle4(input logic v, input logic [3:0] c);
        bus4.sample_valid   = v;
        bus4.orientation_in = c;
        @(negedge clk);
    endtask

    task automatic cycle1(input logic v, input logic [3:0] c);
        bus1.sample_valid   = v;
        bus1.orientation_in = c;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        expect4(tag, 4'd0, 9'h010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scoreboard: every changed pulse must match a queued commit ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus4.changed === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_commit", 16'd1, 16'd0);
            else
                check("commit_code", bus4.orientation_out, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] prev;
        rst_n = 1'b0;
        bus4.sample_valid = 1'b0;  bus4.orientation_in = 4'd0;
        bus1.sample_valid = 1'b0;  bus1.orientation_in = 4'd0;
        repeat (3) @(negedge clk);
        expect4("rst4", 4'd0, 9'h010, 1'b0, 1'b0, 1'b0);
        expect1("rst1", 4'd0, 9'h010, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        expect4("rel4", 4'd0, 9'h010, 1'b0, 1'b0, 1'b0);

        // Four samples of 3 commit on the fourth
        exp_q.push_back(4'd3);
        for (int i = 0; i < 3; i++) begin
            cycle4(1'b1, 4'd3);
            expect4($sformatf("run3_%0d", i), 4'd0, 9'h010, 1'b0, 1'b1, 1'b0);
        end
        cycle4(1'b1, 4'd3);
        expect4("commit3", 4'd3, 9'h020, 1'b1, 1'b0, 1'b0);
        cycle4(1'b0, 4'd0);
        expect4("commit3_after", 4'd3, 9'h020, 1'b0, 1'b0, 1'b0);

        // Abort back to neutral, then a switched candidate commits 5
        do_reset("rst_a");
        cycle4(1'b1, 4'd3);
        cycle4(1'b1, 4'd3);
        cycle4(1'b1, 4'd3);
        expect4("abort_pre", 4'd0, 9'h010, 1'b0, 1'b1, 1'b0);
        cycle4(1'b1, 4'd0);
        expect4("abort", 4'd0, 9'h010, 1'b0, 1'b0, 1'b0);
        cycle4(1'b1, 4'd2);
        cycle4(1'b1, 4'd2);
        cycle4(1'b1, 4'd5);
        expect4("switch5", 4'd0, 9'h010, 1'b0, 1'b1, 1'b0);
        cycle4(1'b1, 4'd5);
        cycle4(1'b1, 4'd5);
        expect4("run5_3", 4'd0, 9'h010, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(4'd5);
        cycle4(1'b1, 4'd5);
        expect4("commit5", 4'd5, 9'h080, 1'b1, 1'b0, 1'b0);

        // Illegal code mid-run sets code_err without disturbing the run
        cycle4(1'b1, 4'd8);
        cycle4(1'b1, 4'd8);
        cycle4(1'b1, 4'd12);
        expect4("illegal", 4'd5, 9'h080, 1'b0, 1'b1, 1'b1);
        cycle4(1'b1, 4'd8);
        expect4("run8_3", 4'd5, 9'h080, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(4'd8);
        cycle4(1'b1, 4'd8);
        expect4("commit8", 4'd8, 9'h001, 1'b1, 1'b0, 1'b1);

        // Sparse samples of 1 with idle gaps
        for (int i = 0; i < 3; i++) begin
            cycle4(1'b1, 4'd1);
            repeat (9) cycle4(1'b0, 4'd1);
            expect4($sformatf("gap1_%0d", i), 4'd8, 9'h001, 1'b0, 1'b1, 1'b1);
        end
        exp_q.push_back(4'd1);
        cycle4(1'b1, 4'd1);
        expect4("commit1", 4'd1, 9'h002, 1'b1, 1'b0, 1'b1);
        cycle4(1'b0, 4'd0);

        // Reset mid-count discards the partial run
        cycle4(1'b1, 4'd4);
        cycle4(1'b1, 4'd4);
        cycle4(1'b1, 4'd4);
        expect4("run4_3", 4'd1, 9'h002, 1'b0, 1'b1, 1'b1);
        bus4.sample_valid = 1'b0;
        do_reset("rst_mid");
        cycle4(1'b1, 4'd4);
        expect4("after_rst4", 4'd0, 9'h010, 1'b0, 1'b1, 1'b0);
        cycle4(1'b0, 4'd0);

        // STABLE_COUNT=1: immediate commit, then walk every code through the LED map
        cycle1(1'b1, 4'd6);
        expect1("c1_commit6", 4'd6, 9'h040, 1'b1, 1'b0, 1'b0);
        prev = 4'd6;
        for (int c = 0; c <= 8; c++) begin
            cycle1(1'b1, 4'(c));
            expect1($sformatf("c1_code%0d", c), 4'(c), led_tab[c], (4'(c) != prev), 1'b0, 1'b0);
            prev = 4'(c);
        end
        cycle1(1'b1, 4'd9);
        expect1("c1_illegal", 4'd8, 9'h001, 1'b0, 1'b0, 1'b1);
        cycle1(1'b0, 4'd0);

        check("commits_left", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
